// File: rtl/outport_arbiter_pkg.sv
// Shared types and widths for the packet-atomic output-port arbiter.
package outport_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    DRAIN  = 2'd2
  } arb_state_e;

  localparam int PKT_CNT_W     = 32;
  localparam int DEF_MAX_BEATS = 64;
  // Width for the default packet limit; the top re-derives it from its own MAX_BEATS.
  localparam int BEAT_CNT_W    = $clog2(DEF_MAX_BEATS);

endpackage

// File: rtl/outport_arbiter_if.sv
// Lane-side and MAC-side stream signals of the output-port arbiter.
interface outport_arbiter_if #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 1024
);
  // Handshakes: a beat moves when valid and ready are both high at a rising
  // edge; lanes hold valid/data/last until accepted, the sink may drop ready anytime.
  logic [N_IN*DATA_W-1:0]          io_in_data;
  logic [N_IN-1:0]                 io_in_valid;
  logic [N_IN-1:0]                 io_in_last;
  logic [N_IN-1:0]                 io_in_ready;
  logic [DATA_W-1:0]               io_data;
  logic                            io_last;
  logic                            io_en;
  logic                            io_ready;
  logic                            io_err_trunc;
  logic [outport_pkg::PKT_CNT_W-1:0] io_pkt_cnt;

  modport master (
    output io_in_data, io_in_valid, io_in_last, io_ready,
    input  io_in_ready, io_data, io_last, io_en, io_err_trunc, io_pkt_cnt
  );

  modport slave (
    input  io_in_data, io_in_valid, io_in_last, io_ready,
    output io_in_ready, io_data, io_last, io_en, io_err_trunc, io_pkt_cnt
  );
endinterface

// File: rtl/outport_arbiter_rr.sv
// Combinational round-robin pick: first requesting lane at or after ptr.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  int               j;
  logic [IDX_W-1:0] jj;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    j       = 0;
    jj      = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = IDX_W'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt_idx = jj;
        gnt[jj] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/outport_arbiter.sv
// Packet-atomic round-robin arbiter feeding one registered output stream,
// with max-length truncation, sticky error flag and packet counter.
module outport_arbiter
  import outport_pkg::*;
#(
  parameter int                   N_IN        = 4,
  parameter int                   DATA_W      = 1024,
  parameter int                   MAX_BEATS   = 64,
  parameter logic [PKT_CNT_W-1:0] PKT_CNT_RST = '0
) (
  input  logic       clock,
  input  logic       reset,
  outport_arbiter_if.slave bus,
  output arb_state_e dbg_state
);

  localparam int               IDX_W      = $clog2(N_IN);
  localparam int               BCW        = $clog2(MAX_BEATS);
  localparam logic [BCW-1:0]   LAST_LEGAL = BCW'(MAX_BEATS - 1);
  localparam logic [IDX_W-1:0] LAST_LANE  = IDX_W'(N_IN - 1);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d, rr_q, rr_d;
  logic [BCW-1:0]       cnt_q, cnt_d;
  logic [N_IN-1:0]      gnt, ready;
  logic [IDX_W-1:0]     gnt_idx, sel;
  logic                 any_req, can_load, accept, forward, force_last, sel_last;
  logic [DATA_W-1:0]    data_q;
  logic                 last_q, en_q, err_q;
  logic [PKT_CNT_W-1:0] pkt_cnt_q;

  function automatic logic [IDX_W-1:0] next_lane(input logic [IDX_W-1:0] i);
    return (i == LAST_LANE) ? '0 : i + IDX_W'(1);
  endfunction

  rr_arbiter #(.N(N_IN), .IDX_W(IDX_W)) u_rr (
    .req     (bus.io_in_valid),
    .ptr     (rr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any_req)
  );

  assign can_load = !en_q || bus.io_ready;
  assign sel      = (state_q == IDLE) ? gnt_idx : owner_q;
  assign sel_last = bus.io_in_last[sel];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (accept) begin
        if (sel_last) begin
          rr_d = next_lane(gnt_idx);
        end else begin
          owner_d = gnt_idx;
          cnt_d   = BCW'(1);
          state_d = LOCKED;
        end
      end
      LOCKED: if (accept) begin
        if (sel_last) begin
          state_d = IDLE;
          rr_d    = next_lane(owner_q);
          cnt_d   = '0;
        end else if (cnt_q == LAST_LEGAL) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + BCW'(1);
        end
      end
      DRAIN: if (accept && sel_last) begin
        state_d = IDLE;
        rr_d    = next_lane(owner_q);
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is gated by reset so nothing is offered while reset is held.
  always_comb begin
    ready = '0;
    unique case (state_q)
      IDLE:    if (can_load && any_req) ready = gnt;
      LOCKED:  if (can_load) ready[owner_q] = 1'b1;
      DRAIN:   ready[owner_q] = 1'b1;
      default: ready = '0;
    endcase
    if (!reset) ready = '0;
    accept     = |(ready & bus.io_in_valid);
    forward    = accept && (state_q != DRAIN);
    force_last = (state_q == LOCKED) && accept && !sel_last && (cnt_q == LAST_LEGAL);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q    <= '0;
      last_q    <= 1'b0;
      en_q      <= 1'b0;
      err_q     <= 1'b0;
      pkt_cnt_q <= PKT_CNT_RST;
    end else begin
      if (en_q && bus.io_ready && last_q) pkt_cnt_q <= pkt_cnt_q + PKT_CNT_W'(1);
      if (force_last) err_q <= 1'b1;
      if (can_load) begin
        en_q <= forward;
        if (forward) begin
          data_q <= bus.io_in_data[int'(sel)*DATA_W +: DATA_W];
          last_q <= sel_last || force_last;
        end
      end
    end
  end

  assign bus.io_in_ready  = ready;
  assign bus.io_data      = data_q;
  assign bus.io_last      = last_q;
  assign bus.io_en        = en_q;
  assign bus.io_err_trunc = err_q;
  assign bus.io_pkt_cnt   = pkt_cnt_q;
  assign dbg_state        = state_q;

endmodule

// File: doc/outport_arbiter.md
# outport_arbiter

Round-robin, packet-atomic arbiter that shares the single 1024-bit output port among `N_IN` pipeline lanes. Each lane presents PHV beats already flattened to `DATA_W` bits, with valid/last. The arbiter grants one lane per packet and holds the grant until that lane's last beat. It drives the registered `io_data`/`io_last`/`io_en` stream toward the MAC-side output port with downstream backpressure, enforces a maximum packet length, and keeps a packet counter.

## Interface
- `N_IN`, default 4: number of requesting lanes; must be at least 2.
- `DATA_W`, default 1024: beat width, equal to 128 PHV bytes × 8.
- `MAX_BEATS`, default 64: longest legal packet in beats; must be at least 2.
- `clock`  input  1  sole clock; everything is rising-edge.
- `reset`  input  1  asynchronous, active-low reset.
- `io_in_data`  input  N_IN*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- `io_in_valid`  input  N_IN  per-lane beat valid.
- `io_in_last`  input  N_IN  per-lane end-of-packet flag, qualified by valid.
- `io_in_ready`  output  N_IN  per-lane beat accept; at most one bit is high.
- `io_data`  output  DATA_W  registered output beat.
- `io_last`  output  1  registered end-of-packet flag.
- `io_en`  output  1  registered output-beat valid.
- `io_ready`  input  1  downstream accept.
- `io_err_trunc`  output  1  sticky: a packet exceeded `MAX_BEATS`.
- `io_pkt_cnt`  output  32  count of packets emitted; wraps at 2^32.

## Operation
- Input handshake: a beat on lane i is accepted when `io_in_valid[i] & io_in_ready[i]`.
- Output handshake: an output beat completes when `io_en & io_ready`.
- The output register can load when `!io_en | io_ready`.
- `io_in_ready[i]` is high only when lane i is the selected lane, the output register can load, and the state is not DRAIN. In DRAIN the owner lane is ready unconditionally.
- State IDLE:
  - The round-robin pick searches the valid lanes starting at `rr_ptr`; the first valid lane found is the winner.
  - The winner's first beat is accepted in the same cycle if the output register can load.
  - If that beat has `last=1`, the state stays IDLE and `rr_ptr` becomes winner+1 mod N_IN.
  - Otherwise `owner` is set to the winner, `beat_cnt` to 1, and the state moves to LOCKED.
- State LOCKED:
  - Only `owner` is considered; each accepted beat increments `beat_cnt`.
  - An accepted beat with `last=1` moves the state to IDLE and sets `rr_ptr` to owner+1.
  - An accepted beat without last while `beat_cnt == MAX_BEATS-1` is forwarded with `io_last` forced to 1. It also sets `io_err_trunc` and moves the state to DRAIN.
- State DRAIN: owner beats are accepted and discarded, not forwarded. The owner's last beat moves the state to IDLE and sets `rr_ptr` to owner+1.
- `io_pkt_cnt` increments on every completed output beat with `io_last=1`, including forced lasts.
- Other lanes' valid/last inputs are ignored while the arbiter is LOCKED or in DRAIN.
- `io_last` is meaningful only while `io_en=1`.

## Timing
- Latency: an accepted input beat appears on `io_data/io_last/io_en` the next cycle.
- Throughput: one beat per cycle while `io_ready=1`, including back-to-back packets from different lanes with no bubble.
- Backpressure: with `io_en=1` and `io_ready=0`, the output register holds its value and every `io_in_ready` is 0, except the owner in DRAIN.
- Reset values (asynchronous, while `reset=0`):
  - `io_en`, `io_last`, `io_data`, `io_err_trunc`, `io_pkt_cnt`, `io_in_ready` all 0.
  - State IDLE, `rr_ptr` 0, `beat_cnt` 0.
- Reset asserted mid-packet abandons the packet; after release the arbiter re-arbitrates from lane 0.
- Single-beat packets never enter LOCKED.
- A last beat arriving exactly at `beat_cnt == MAX_BEATS-1` is legal: no error is flagged and the state returns to IDLE.

## Structure
- Package `outport_pkg` holds:
  - enum `arb_state_e` with values {IDLE, LOCKED, DRAIN};
  - localparams `PKT_CNT_W=32` and `BEAT_CNT_W=$clog2(MAX_BEATS)`.
- Sub-module `rr_arbiter`: combinational. Takes the request vector and `rr_ptr`, returns a one-hot grant and the grant index. It is instantiated once, for the IDLE pick.
- The top level holds the FSM, `owner`, `beat_cnt`, the output register and the counters.

## Test plan
- Single lane, 3-beat packet with `io_ready=1`: beats appear one cycle later; `io_last` is set on the third beat; `io_pkt_cnt=1`.
- Lanes 0–3 all valid, each sending 2-beat packets: output order is lane 0,1,2,3,0; packets never interleave; no idle cycles.
- `io_ready` held low for 5 cycles mid-packet: the output beat is held stable; all `io_in_ready=0`; the stream resumes without beat loss or duplication.
- `MAX_BEATS=4`, lane 1 sends 6 beats:
  - beats 1–4 are forwarded, with `io_last` on beat 4;
  - beats 5–6 are discarded;
  - `io_err_trunc=1` and `io_pkt_cnt=1`;
  - lane 2 is served next.
- Assert `reset=0` during beat 2 of a packet on lane 2, then release: all outputs are 0; after release, a pending lane-0 request is granted first.
- Preload `io_pkt_cnt` to 0xFFFF_FFFF, then send one packet: the counter wraps to 0.
